// File: rtl/hdr_pkg.sv
// hdr_merge_n shared types and helpers.
// Mode enum, sideband bit layout, width helpers, hat weight.
package hdr_pkg;

  typedef enum logic {
    HDR_MERGE  = 1'b0,
    HDR_BYPASS = 1'b1
  } hdr_mode_e;

  // Sideband bus layout: {pix, mode, eol, sof, valid}
  localparam int SB_VLD  = 0;
  localparam int SB_SOF  = 1;
  localparam int SB_EOL  = 2;
  localparam int SB_MODE = 3;
  localparam int SB_PIX  = 4;

  function automatic int NUM_W(input int dw, input int n);
    return 2 * dw + $clog2(n);
  endfunction

  function automatic int DEN_W(input int dw, input int n);
    return dw + $clog2(n);
  endfunction

  function automatic int HDR_LAT(input int dw);
    return dw + 4;
  endfunction

  // Hat weight min(z, maxv-z), floored at w_min.
  function automatic logic [11:0] hat_weight(
    input logic [11:0] z,
    input int          dw,
    input int          w_min
  );
    int zi;
    int maxv;
    int w;
    zi   = int'(z);
    maxv = (1 << dw) - 1;
    w    = (zi < maxv - zi) ? zi : maxv - zi;
    if (w < w_min) w = w_min;
    return 12'(w);
  endfunction

endpackage

// File: rtl/hdr_merge_n_divider.sv
// Pipelined restoring divider, one quotient bit per stage.
// Ports: num_i/den_i/sb_i in; q_o, rnz_o, sb_o after Q_W clocks.
module hdr_pipe_divider #(
  parameter int NUM_W = 17,
  parameter int DEN_W = 9,
  parameter int Q_W   = 8,
  parameter int SB_W  = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NUM_W-1:0] num_i,
  input  logic [DEN_W-1:0] den_i,
  input  logic [SB_W-1:0]  sb_i,
  output logic [Q_W-1:0]   q_o,
  output logic             rnz_o,
  output logic [SB_W-1:0]  sb_o
);

  logic [NUM_W-1:0] rem_q [Q_W];
  logic [Q_W-1:0]   quo_q [Q_W];
  logic [SB_W-1:0]  sb_q  [Q_W];
  logic [DEN_W-1:0] den_q [Q_W];

  for (genvar s = 0; s < Q_W; s++) begin : g_st
    localparam int SH = Q_W - 1 - s;

    logic [NUM_W-1:0] rem_in;
    logic [DEN_W-1:0] den_in;
    logic [Q_W-1:0]   quo_in;
    logic [SB_W-1:0]  sb_in;
    logic [NUM_W:0]   dsh;
    logic [NUM_W:0]   diff;
    logic             ge;
    logic [Q_W-1:0]   quo_d;
    logic [NUM_W-1:0] rem_d;

    if (s == 0) begin : g_in0
      assign rem_in = num_i;
      assign den_in = den_i;
      assign quo_in = '0;
      assign sb_in  = sb_i;
    end else begin : g_inn
      assign rem_in = rem_q[s-1];
      assign den_in = den_q[s-1];
      assign quo_in = quo_q[s-1];
      assign sb_in  = sb_q[s-1];
    end

    // Borrow out of the trial subtraction decides the bit.
    assign dsh  = (NUM_W + 1)'(den_in) << SH;
    assign diff = {1'b0, rem_in} - dsh;
    assign ge   = ~diff[NUM_W];

    always_comb begin
      quo_d     = quo_in;
      quo_d[SH] = ge;
      rem_d     = ge ? diff[NUM_W-1:0] : rem_in;
    end

    always_ff @(posedge clk) begin
      rem_q[s] <= rem_d;
      quo_q[s] <= quo_d;
      den_q[s] <= den_in;
    end

    always_ff @(posedge clk) begin
      if (rst) sb_q[s] <= '0;
      else     sb_q[s] <= sb_in;
    end
  end

  assign q_o   = quo_q[Q_W-1];
  assign rnz_o = |rem_q[Q_W-1];
  assign sb_o  = sb_q[Q_W-1];

endmodule

// File: rtl/hdr_merge_n.sv
// N-exposure HDR merge: hat-weighted mean, rounded up, 1 pix/clk.
// Ports: in_valid/sof/eol, data_i, cfg_mode/sel in; out_* and data_o.
module hdr_merge_n
  import hdr_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_EXP    = 2,
  parameter int W_MIN      = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic                          in_sof,
  input  logic                          in_eol,
  input  logic [NUM_EXP*DATA_WIDTH-1:0] data_i,
  input  logic                          cfg_mode,
  input  logic [1:0]                    cfg_sel,
  output logic                          out_valid,
  output logic                          out_sof,
  output logic                          out_eol,
  output logic [DATA_WIDTH-1:0]         data_o
);

  localparam int DW  = DATA_WIDTH;
  localparam int N   = NUM_EXP;
  localparam int NW  = NUM_W(DW, N);
  localparam int DNW = DEN_W(DW, N);
  localparam int PW  = 2 * DW;
  localparam int SBW = DW + 4;

  hdr_mode_e      mode_q, mode_d;
  logic [1:0]     sel_q, sel_d;
  logic [DW-1:0]  z_in [N];
  logic [DW-1:0]  w_in [N];
  logic [DW-1:0]  byp_pix;

  always_comb begin
    for (int k = 0; k < N; k++) begin
      z_in[k] = data_i[k*DW +: DW];
      w_in[k] = DW'(hat_weight(12'(z_in[k]), DW, W_MIN));
    end
  end

  // The sof pixel already uses the newly sampled config.
  always_comb begin
    mode_d = mode_q;
    sel_d  = sel_q;
    if (in_valid && in_sof) begin
      mode_d = cfg_mode ? HDR_BYPASS : HDR_MERGE;
      sel_d  = (int'(cfg_sel) < N) ? cfg_sel : 2'd0;
    end
    byp_pix = z_in[0];
    for (int k = 1; k < N; k++)
      if (int'(sel_d) == k) byp_pix = z_in[k];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= HDR_MERGE;
      sel_q  <= 2'd0;
    end else begin
      mode_q <= mode_d;
      sel_q  <= sel_d;
    end
  end

  logic [DW-1:0]  z1_q [N];
  logic [DW-1:0]  w1_q [N];
  logic [PW-1:0]  p2_q [N];
  logic [DNW-1:0] den2_q, den3_q, den_d;
  logic [NW-1:0]  num3_q, num_d;
  logic [SBW-1:0] sb1_q, sb2_q, sb3_q, sb_div;

  always_comb begin
    den_d = '0;
    num_d = '0;
    for (int k = 0; k < N; k++) begin
      den_d = den_d + DNW'(w1_q[k]);
      num_d = num_d + NW'(p2_q[k]);
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < N; k++) begin
      z1_q[k] <= z_in[k];
      w1_q[k] <= w_in[k];
      p2_q[k] <= PW'(w1_q[k]) * PW'(z1_q[k]);
    end
    den2_q <= den_d;
    num3_q <= num_d;
    den3_q <= den2_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sb1_q <= '0;
      sb2_q <= '0;
      sb3_q <= '0;
    end else begin
      sb1_q <= {byp_pix, mode_d == HDR_BYPASS,
                in_eol, in_sof, in_valid};
      sb2_q <= sb1_q;
      sb3_q <= sb2_q;
    end
  end

  logic [DW-1:0] q_div;
  logic          rnz;

  hdr_pipe_divider #(
    .NUM_W (NW),
    .DEN_W (DNW),
    .Q_W   (DW),
    .SB_W  (SBW)
  ) u_div (
    .clk   (clk),
    .rst   (rst),
    .num_i (num3_q),
    .den_i (den3_q),
    .sb_i  (sb3_q),
    .q_o   (q_div),
    .rnz_o (rnz),
    .sb_o  (sb_div)
  );

  logic [DW:0]   qr;
  logic [DW-1:0] mres, res_d;
  logic          vld_q, sof_q, eol_q;
  logic [DW-1:0] data_q;

  assign qr    = {1'b0, q_div} + {{DW{1'b0}}, rnz};
  assign mres  = qr[DW] ? {DW{1'b1}} : qr[DW-1:0];
  assign res_d = sb_div[SB_MODE] ? sb_div[SB_PIX +: DW] : mres;

  // data_o holds between pixels so it stays 0 after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= 1'b0;
      sof_q  <= 1'b0;
      eol_q  <= 1'b0;
      data_q <= '0;
    end else begin
      vld_q <= sb_div[SB_VLD];
      sof_q <= sb_div[SB_SOF] & sb_div[SB_VLD];
      eol_q <= sb_div[SB_EOL] & sb_div[SB_VLD];
      if (sb_div[SB_VLD]) data_q <= res_d;
    end
  end

  assign out_valid = vld_q;
  assign out_sof   = sof_q;
  assign out_eol   = eol_q;
  assign data_o    = data_q;

endmodule

// File: tb/tb_hdr_merge_n.sv
// Directed bench for hdr_merge_n (N=2 and N=3 instances).
// Hand-computed vectors: merge, bypass, markers, reset.
module tb_hdr_merge_n;
  import hdr_pkg::*;

  localparam int L = HDR_LAT(8);

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_sof, in_eol;
  logic        cfg_mode;
  logic [1:0]  cfg_sel;
  logic [15:0] d2;
  logic [23:0] d3;
  logic        ov2, os2, oe2, ov3, os3, oe3;
  logic [7:0]  do2, do3;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  hdr_merge_n #(
    .DATA_WIDTH(8), .NUM_EXP(2), .W_MIN(1)
  ) u_dut2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_sof(in_sof),
    .in_eol(in_eol), .data_i(d2),
    .cfg_mode(cfg_mode), .cfg_sel(cfg_sel),
    .out_valid(ov2), .out_sof(os2),
    .out_eol(oe2), .data_o(do2)
  );

  hdr_merge_n #(
    .DATA_WIDTH(8), .NUM_EXP(3), .W_MIN(1)
  ) u_dut3 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_sof(in_sof),
    .in_eol(in_eol), .data_i(d3),
    .cfg_mode(cfg_mode), .cfg_sel(cfg_sel),
    .out_valid(ov3), .out_sof(os3),
    .out_eol(oe3), .data_o(do3)
  );

  task automatic drive(input logic v, input logic s,
                       input logic e, input int a,
                       input int b, input int c,
                       input logic m, input logic [1:0] sel);
    in_valid = v;
    in_sof   = s;
    in_eol   = e;
    d2       = {8'(b), 8'(a)};
    d3       = {8'(c), 8'(b), 8'(a)};
    cfg_mode = m;
    cfg_sel  = sel;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 2'd0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    repeat (3) @(negedge clk);
    checks++;
    if ({ov2, os2, oe2, do2} !== 11'd0) begin
      errors++;
      $display("FAIL reset_n2 got %h exp 000",
               {ov2, os2, oe2, do2});
    end
    checks++;
    if ({ov3, os3, oe3, do3} !== 11'd0) begin
      errors++;
      $display("FAIL reset_n3 got %h exp 000",
               {ov3, os3, oe3, do3});
    end
    rst = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      checks++;
      if (ov2 !== 1'b0 || do2 !== 8'd0) begin
        errors++;
        $display("FAIL post_reset[%0d] got v=%b d=%0d exp v=0 d=0",
                 n, ov2, do2);
      end
    end
  endtask

  task automatic test_merge_basic();
    @(negedge clk);
    drive(1, 1, 1, 100, 200, 0, 0, 2'd0);
    for (int n = 1; n <= L + 1; n++) begin
      @(negedge clk);
      if (n == 1) idle();
      checks++;
      if (ov2 !== (n == L)) begin
        errors++;
        $display("FAIL latency[%0d] got v=%b exp v=%b",
                 n, ov2, (n == L));
      end
      if (n == L) begin
        checks++;
        if (do2 !== 8'd136) begin
          errors++;
          $display("FAIL merge_basic got %0d exp 136", do2);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int za[8] = '{100, 0, 255, 128, 50, 10, 255, 127};
    int zb[8] = '{200, 0, 255, 64, 50, 20, 0, 128};
    int ex[8] = '{136, 0, 255, 107, 50, 17, 128, 128};
    for (int n = 0; n <= 8 + L; n++) begin
      @(negedge clk);
      if (n >= L && n - L < 8) begin
        checks++;
        if (ov2 !== 1'b1 || do2 !== 8'(ex[n-L])) begin
          errors++;
          $display("FAIL b2b[%0d] got v=%b d=%0d exp v=1 d=%0d",
                   n - L, ov2, do2, ex[n-L]);
        end
      end else if (n >= L) begin
        checks++;
        if (ov2 !== 1'b0) begin
          errors++;
          $display("FAIL b2b_tail got v=%b exp v=0", ov2);
        end
      end
      if (n < 8) drive(1, n == 0, n == 7, za[n], zb[n], 0, 0, 2'd0);
      else       idle();
    end
  endtask

  task automatic test_merge_n3();
    int za[5] = '{10, 0, 255, 100, 0};
    int zb[5] = '{128, 0, 255, 100, 255};
    int zc[5] = '{250, 0, 255, 100, 128};
    int ex[5] = '{124, 0, 255, 100, 128};
    for (int n = 0; n <= 5 + L; n++) begin
      @(negedge clk);
      if (n >= L && n - L < 5) begin
        checks++;
        if (ov3 !== 1'b1 || do3 !== 8'(ex[n-L])) begin
          errors++;
          $display("FAIL n3[%0d] got v=%b d=%0d exp v=1 d=%0d",
                   n - L, ov3, do3, ex[n-L]);
        end
      end
      if (n < 5) drive(1, n == 0, 0, za[n], zb[n], zc[n], 0, 2'd0);
      else       idle();
    end
  endtask

  task automatic test_bypass();
    int        za[7] = '{100, 128, 10, 100, 50, 10, 255};
    int        zb[7] = '{200, 64, 20, 200, 50, 20, 0};
    logic      sf[7] = '{1, 0, 0, 1, 0, 1, 0};
    logic      md[7] = '{1, 0, 0, 0, 1, 1, 0};
    logic [1:0] sl[7] = '{1, 0, 0, 1, 1, 3, 0};
    int        ex[7] = '{200, 64, 20, 136, 50, 10, 255};
    for (int n = 0; n <= 7 + L; n++) begin
      @(negedge clk);
      if (n >= L && n - L < 7) begin
        checks++;
        if (ov2 !== 1'b1 || do2 !== 8'(ex[n-L])) begin
          errors++;
          $display("FAIL bypass[%0d] got v=%b d=%0d exp v=1 d=%0d",
                   n - L, ov2, do2, ex[n-L]);
        end
      end
      if (n < 7) drive(1, sf[n], 0, za[n], zb[n], 0, md[n], sl[n]);
      else       idle();
    end
  endtask

  task automatic test_markers();
    logic v[5]  = '{1, 0, 0, 1, 1};
    logic s[5]  = '{1, 1, 0, 0, 0};
    logic e[5]  = '{0, 0, 1, 0, 1};
    int   za[5] = '{100, 0, 0, 128, 10};
    int   zb[5] = '{200, 0, 0, 64, 20};
    int   ex[5] = '{136, 0, 0, 107, 17};
    logic [2:0] eo, go;
    for (int n = 0; n <= L + 6; n++) begin
      @(negedge clk);
      if (n >= L) begin
        if (n - L < 5)
          eo = {v[n-L], v[n-L] & s[n-L], v[n-L] & e[n-L]};
        else
          eo = 3'b000;
        go = {ov2, os2, oe2};
        checks++;
        if (go !== eo) begin
          errors++;
          $display("FAIL markers[%0d] got vse=%b exp vse=%b",
                   n - L, go, eo);
        end
        if (n - L < 5 && v[n-L]) begin
          checks++;
          if (do2 !== 8'(ex[n-L])) begin
            errors++;
            $display("FAIL marker_data[%0d] got %0d exp %0d",
                     n - L, do2, ex[n-L]);
          end
        end
      end
      if (n < 5) drive(v[n], s[n], e[n], za[n], zb[n], 0, n == 1, 2'd1);
      else       idle();
    end
  endtask

  task automatic test_reset_mid();
    for (int n = 0; n <= 21; n++) begin
      @(negedge clk);
      if (n >= 5 && n <= 19) begin
        checks++;
        if (ov2 !== 1'b0 || os2 !== 1'b0 || oe2 !== 1'b0 ||
            (n >= 6 && do2 !== 8'd0)) begin
          errors++;
          $display("FAIL flush[%0d] got v=%b s=%b e=%b d=%0d exp 0",
                   n, ov2, os2, oe2, do2);
        end
      end
      if (n == 20) begin
        checks++;
        if (ov2 !== 1'b1 || do2 !== 8'd136) begin
          errors++;
          $display("FAIL after_reset got v=%b d=%0d exp v=1 d=136",
                   ov2, do2);
        end
      end
      if (n == 21) begin
        checks++;
        if (ov2 !== 1'b0) begin
          errors++;
          $display("FAIL after_reset_tail got v=%b exp v=0", ov2);
        end
      end
      rst = (n == 5);
      if (n < 5)       drive(1, n == 0, 0, 100, 200, 0, 1, 2'd1);
      else if (n == 8) drive(1, 0, 0, 100, 200, 0, 1, 2'd1);
      else             idle();
    end
  endtask

  initial begin
    test_reset();
    test_merge_basic();
    test_back_to_back();
    test_merge_n3();
    test_bypass();
    test_markers();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/hdr_merge_n.md
Name: hdr_merge_n

Overview:
- Streaming N-exposure HDR pixel merger. Successor to the 2-exposure merge path.
- Takes NUM_EXP co-located luminance samples per cycle and computes a weighted mean using a hat weight function with a floor. The result is rounded up.
- Fully pipelined at 1 pixel/clk, with valid and frame/line markers aligned to the data.
- Runtime bypass mode forwards one selected exposure. The mode is latched per frame.
- Sits between the exposure alignment buffers and the tone-mapping stage.

Parameters:
- DATA_WIDTH, 8: bits per pixel sample, legal range 4..12.
- NUM_EXP, 2: number of exposures merged, legal range 2..4.
- W_MIN, 1: weight floor, must be ≥1. This guarantees a nonzero denominator.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  input sample set valid
- in_sof  in  1  first pixel of frame, qualified by in_valid
- in_eol  in  1  last pixel of line, qualified by in_valid
- data_i  in  NUM_EXP*DATA_WIDTH  packed exposures; exposure k occupies bits [k*DW +: DW]
- cfg_mode  in  1  0 = merge, 1 = bypass
- cfg_sel  in  2  exposure index used in bypass
- out_valid  out  1  output valid
- out_sof  out  1  aligned copy of in_sof
- out_eol  out  1  aligned copy of in_eol
- data_o  out  DATA_WIDTH  merged or bypassed pixel

Behaviour:
- Reset: out_valid, out_sof, out_eol and data_o are 0. The valid/marker shift chain is cleared. Mode register resets to merge, sel to 0.
- Reset mid-frame flushes all in-flight pixels; no out_valid until L cycles after the first in_valid following reset deassertion.
- No backpressure. Every in_valid produces exactly one out_valid, with fixed latency L = DATA_WIDTH + 4 (12 at default). Gaps in in_valid are preserved at the output.
- Mode latch: cfg_mode/cfg_sel are sampled only on a cycle with in_valid & in_sof. The latched value travels down the pipe with the pixel. Changes mid-frame have no effect until the next sof. cfg_sel ≥ NUM_EXP is treated as 0.
- Pipeline stages:
  - S1 registers the samples and weights. MAXV = 2^DW-1; w_k = min(Z_k, MAXV-Z_k); if w_k < W_MIN then w_k = W_MIN. w_k is DW bits.
  - S2 registers products p_k = w_k*Z_k (2*DW bits) and den = Σw_k (DW+clog2(NUM_EXP) bits).
  - S3 registers num = Σp_k (2*DW+clog2(NUM_EXP) bits). den is delayed alongside it.
  - S4..S(DW+3): pipelined restoring divider, one quotient bit per stage, MSB first. Produces DW quotient bits plus a remainder-nonzero flag.
  - Final stage: q + (rem≠0), saturated to MAXV.
- Quotient cannot exceed MAXV mathematically, since it is a weighted mean of samples. Saturation is a guard only.
- Bypass: the selected Z_k is captured at S1 and delayed so that its output timing equals merge timing. The divider result is ignored for that pixel.
- Markers: out_sof/out_eol equal the delayed in_sof/in_eol ANDed with the delayed valid. They are 0 when out_valid is 0.
- Data on non-valid cycles is don't-care except after reset, where it is 0.

Decomposition:
- Package hdr_pkg holds:
  - enum hdr_mode_e {HDR_MERGE, HDR_BYPASS}
  - function hat_weight(Z, DW, W_MIN)
  - localparam helpers NUM_W(DW,N), DEN_W(DW,N), HDR_LAT(DW)
- Sub-module hdr_pipe_divider, parameters NUM_W, DEN_W, Q_W:
  - Q_W-stage pipelined restoring divider.
  - Carries a sideband bus (valid, sof, eol, mode, bypass pixel) through its stages so alignment is structural.
  - No reset on the datapath; the sideband valid is reset.

Test Plan:
1. DW=8, N=2, merge: Z=(100,200) → w=(100,55), num=21000, den=155 → data_o=136 exactly 12 cycles after in_valid.
2. DW=8, N=2 extremes: (0,0) → 0; (255,255) → w floored to (1,1) → 255; (128,64) → 20352/191 rem≠0 → 107.
3. DW=8, N=3: Z=(10,128,250) → w=(10,127,5), num=17606, den=142 → 124. Also back-to-back random pixels checked against a golden model at 1 pixel/clk with no bubbles.
4. Bypass: sof pixel with cfg_mode=1, cfg_sel=1 → data_o = Z1 for the whole frame. Flip cfg_sel to 0 mid-frame → no change. Next sof with cfg_mode=0 → merged values resume.
5. Valid gaps and markers: pattern 1,0,0,1,1 on in_valid with sof on the first pixel and eol on the last → identical pattern on out_valid at +12. out_sof/out_eol land on the matching pixels only.
6. Reset mid-stream: assert rst for 1 cycle while 5 pixels are in flight → none emerge. Outputs are 0 during and after reset. The first new pixel appears exactly 12 cycles after its in_valid.
